// File: rtl/gen_fold_frame.sv
// gen_fold_frame: folds consecutive accepted W-bit samples into frames of FRAME
// samples. For each bit lane it produces the parity (XOR) over the frame and a
// majority flag (ones count > FRAME/2). One result word per frame is emitted on a
// valid/ready interface, tagged with a wrapping frame sequence number.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        (GEN_FOLD_SYNC_CLR_EN only) synchronous abandon of the partial frame
//   in_valid   sample present
//   in_data    sample, one bit per lane
//   in_ready   block can accept in_data this cycle (independent of in_valid)
//   out_valid  result word present
//   out_ready  consumer accepts result
//   out_xor    per-lane XOR over the frame
//   out_maj    per-lane majority over the frame
//   out_seq    frame sequence number
//
// Optional feature macro: GEN_FOLD_SYNC_CLR_EN adds the clr input.

module gen_fold_frame #(
    parameter int unsigned W     = 8,
    parameter int unsigned FRAME = 5,
    parameter int unsigned SEQW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef GEN_FOLD_SYNC_CLR_EN
    input  logic            clr,
`endif
    input  logic            in_valid,
    input  logic [W-1:0]    in_data,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_xor,
    output logic [W-1:0]    out_maj,
    output logic [SEQW-1:0] out_seq
);

    localparam int unsigned CW = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LastIdx = CW'(FRAME - 1);
    localparam logic [CW-1:0] Half    = CW'(FRAME / 2);

    logic            clr_en;
    logic [CW-1:0]   scnt_q, scnt_d;
    logic [SEQW-1:0] fcnt_q, fcnt_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_xor_q, out_xor_d;
    logic [W-1:0]    out_maj_q, out_maj_d;
    logic [SEQW-1:0] out_seq_q, out_seq_d;
    logic [W-1:0]    xor_fin, maj_fin;
    logic            last, take, done, flush, step;

`ifdef GEN_FOLD_SYNC_CLR_EN
    assign clr_en = clr;
`else
    assign clr_en = 1'b0;
`endif

    assign last = (scnt_q == LastIdx);
    // Only the frame-completing sample stalls behind a pending word.
    assign in_ready = !(out_valid_q && !out_ready && last) && !clr_en;
    assign take     = in_valid && in_ready;
    assign done     = take && last;
    assign flush    = clr_en || done;
    assign step     = take && !last;

    for (genvar i = 0; i < W; i++) begin : g_lane
        logic          acc_q, acc_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [CW-1:0] sum;

        assign sum        = cnt_q + CW'(in_data[i]);
        assign xor_fin[i] = acc_q ^ in_data[i];
        assign maj_fin[i] = (sum > Half);

        always_comb begin
            acc_d = acc_q;
            cnt_d = cnt_q;
            if (flush) begin
                acc_d = 1'b0;
                cnt_d = '0;
            end else if (step) begin
                acc_d = acc_q ^ in_data[i];
                cnt_d = sum;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
        end
    end

    always_comb begin
        scnt_d      = scnt_q;
        fcnt_d      = fcnt_q;
        out_valid_d = out_valid_q;
        out_xor_d   = out_xor_q;
        out_maj_d   = out_maj_q;
        out_seq_d   = out_seq_q;

        if (flush) begin
            scnt_d = '0;
        end else if (step) begin
            scnt_d = scnt_q + CW'(1);
        end

        // done implies the output slot is free or retiring on this edge.
        if (done) begin
            out_valid_d = 1'b1;
            out_xor_d   = xor_fin;
            out_maj_d   = maj_fin;
            out_seq_d   = fcnt_q;
            fcnt_d      = fcnt_q + SEQW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q      <= '0;
            fcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_xor_q   <= '0;
            out_maj_q   <= '0;
            out_seq_q   <= '0;
        end else begin
            scnt_q      <= scnt_d;
            fcnt_q      <= fcnt_d;
            out_valid_q <= out_valid_d;
            out_xor_q   <= out_xor_d;
            out_maj_q   <= out_maj_d;
            out_seq_q   <= out_seq_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_xor   = out_xor_q;
    assign out_maj   = out_maj_q;
    assign out_seq   = out_seq_q;

endmodule

// File: tb/tb_gen_fold_frame.sv
// Scoreboard bench for gen_fold_frame (W=8, FRAME=5, SEQW=4). Stimulus pushes
// hand-computed result words; a negedge monitor compares every presented word.

module tb_gen_fold_frame;

    localparam int W     = 8;
    localparam int FRAME = 5;
    localparam int SEQW  = 4;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            in_valid  = 1'b0;
    logic [W-1:0]    in_data   = '0;
    logic            out_ready = 1'b1;
    logic            in_ready;
    logic            out_valid;
    logic [W-1:0]    out_xor;
    logic [W-1:0]    out_maj;
    logic [SEQW-1:0] out_seq;
`ifdef GEN_FOLD_SYNC_CLR_EN
    logic            clr = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] m;
        logic [3:0] s;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp    = 0;
    int n_bad    = 0;
    int n_words  = 0;
    int n_pushed = 0;

    gen_fold_frame #(
        .W     (W),
        .FRAME (FRAME),
        .SEQW  (SEQW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef GEN_FOLD_SYNC_CLR_EN
        .clr       (clr),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_xor   (out_xor),
        .out_maj   (out_maj),
        .out_seq   (out_seq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] m, input logic [3:0] s);
        exp_t e;
        e.x = x;
        e.m = m;
        e.s = s;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Monitor: compare whatever word is presented; retire it on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got xor=%h maj=%h seq=%0d, expected no word",
                         out_xor, out_maj, out_seq);
            end else begin
                check("out_xor", 32'(out_xor), 32'(exp_q[0].x));
                check("out_maj", 32'(out_maj), 32'(exp_q[0].m));
                check("out_seq", 32'(out_seq), 32'(exp_q[0].s));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_words++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the sample's accepting edge.
    task automatic send(input logic [W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("send_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_xor", 32'(out_xor), 32'd0);
        check("rst_out_maj", 32'(out_maj), 32'd0);
        check("rst_out_seq", 32'(out_seq), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Wait for all expected words to retire, then the output must be idle.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int w0;
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        @(posedge clk);
        #1;

        // Basic frame
        do_reset();
        push(8'h15, 8'h07, 4'd0);
        send(8'h01);
        send(8'h03);
        send(8'h07);
        send(8'h0F);
        send(8'h1F);
        check("basic_valid", 32'(out_valid), 32'd1);
        drain("basic");

        // Backpressure: ten 0xFF samples with out_ready low
        do_reset();
        out_ready = 1'b0;
        push(8'hFF, 8'hFF, 4'd0);
        push(8'hFF, 8'hFF, 4'd1);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            #1;
            check("bp_in_ready", 32'(in_ready), (k == 9) ? 32'd0 : 32'd1);
            if (k < 9) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (2) begin
            @(posedge clk);
            #2;
            check("bp_stall_in_ready", 32'(in_ready), 32'd0);
            check("bp_held_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_no_gap", 32'(out_valid), 32'd1);
        drain("bp");

        // Simultaneous retire and frame completion
        do_reset();
        out_ready = 1'b0;
        w0 = n_words;
        push(8'h81, 8'h81, 4'd0);
        push(8'h3C, 8'h3C, 4'd1);
        repeat (5) send(8'h81);
        send(8'h0F);
        send(8'h0F);
        send(8'hF0);
        send(8'hF0);
        check("sim_pending", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        send(8'h3C);
        check("sim_valid_hold", 32'(out_valid), 32'd1);
        drain("sim");
        check("sim_words", 32'(n_words - w0), 32'd2);

        // Sequence wrap-around
        do_reset();
        for (int f = 0; f < 17; f++) begin
            push(8'h00, 8'h00, 4'(f % 16));
            repeat (5) send(8'h00);
        end
        drain("wrap");

        // Reset mid-frame
        do_reset();
        repeat (3) send(8'hAA);
        do_reset();
        push(8'h55, 8'h55, 4'd0);
        repeat (5) send(8'h55);
        drain("midrst");

`ifdef GEN_FOLD_SYNC_CLR_EN
        // Synchronous clear abandons the partial frame and drops its sample
        do_reset();
        push(8'h01, 8'h01, 4'd0);
        send(8'h0F);
        send(8'h0F);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #1;
        check("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        repeat (5) send(8'h01);
        drain("clr");
`endif

        check("words_total", 32'(n_words), 32'(n_pushed));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
